// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one registered memory port between I-cache and D-cache
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_mem_read,
   input  logic [ADDR_W-1:0] ic_mem_addr,
   output logic [LINE_W-1:0] ic_mem_rdata,
   output logic              ic_mem_ready,
   input  logic              dc_mem_read,
   input  logic              dc_mem_write,
   input  logic [ADDR_W-1:0] dc_mem_addr,
   input  logic [LINE_W-1:0] dc_mem_wdata,
   output logic [LINE_W-1:0] dc_mem_rdata,
   output logic              dc_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   state_t state, state_nx;
   logic last_d;
   logic req_i, req_d, pick_d;
   assign req_i  = ic_mem_read;
   assign req_d  = dc_mem_read | dc_mem_write;
   assign pick_d = req_d & (~req_i | ~last_d);
   // next state: grant from IDLE (D wins a tie unless it went last), return to IDLE on mem_ready
   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = pick_d ? SERVE_D : req_i ? SERVE_I : IDLE;
      else if (mem_ready)
         state_nx = IDLE;
   end
   // state register and round-robin history, updated when a transaction completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         state <= state_nx;
         if (state != IDLE && mem_ready)
            last_d <= (state == SERVE_D);
      end
   end
   // memory request registers: loaded at the grant edge, held while serving, cleared on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (state == IDLE) begin
         if (state_nx == SERVE_D) begin
            mem_addr  <= dc_mem_addr;
            mem_wdata <= dc_mem_wdata;
            mem_write <= dc_mem_write;
            mem_read  <= dc_mem_read & ~dc_mem_write;
         end else if (state_nx == SERVE_I) begin
            mem_addr  <= ic_mem_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
         end
      end else if (mem_ready) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end
   end
   // response routing: only the client being served sees the memory response
   always_comb begin
      ic_mem_ready = (state == SERVE_I) & mem_ready;
      dc_mem_ready = (state == SERVE_D) & mem_ready;
      ic_mem_rdata = (state == SERVE_I) ? mem_rdata : '0;
      dc_mem_rdata = (state == SERVE_D) ? mem_rdata : '0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level arbiter model checked every cycle
module tb_mem_arbiter;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          ic_mem_read, ic_mem_ready;
   logic [27:0]   ic_mem_addr;
   logic [127:0]  ic_mem_rdata;
   logic          dc_mem_read, dc_mem_write, dc_mem_ready;
   logic [27:0]   dc_mem_addr;
   logic [127:0]  dc_mem_wdata, dc_mem_rdata;
   logic          mem_read, mem_write, mem_ready;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata, mem_rdata;
   int tests = 0;
   int fails = 0;

   mem_arbiter #(.ADDR_W(28), .LINE_W(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
      .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
      .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
      .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
      .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", n, a, e, $time);
      end
   endtask

   // model: who is being served (0 none, 1 I, 2 D), who went last, and what memory must see
   int           cur = 0;
   int           last = 1;
   int           who;
   logic         e_rd = 1'b0, e_wr = 1'b0;
   logic [27:0]  e_addr = '0;
   logic [127:0] e_wdata = '0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur = 0; last = 1; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      end else if (cur == 0) begin
         if (ic_mem_read && (dc_mem_read || dc_mem_write)) who = 3 - last;
         else if (ic_mem_read) who = 1;
         else if (dc_mem_read || dc_mem_write) who = 2;
         else who = 0;
         if (who == 1) begin
            e_addr = ic_mem_addr; e_rd = 1; e_wr = 0;
         end
         if (who == 2) begin
            e_addr = dc_mem_addr; e_wdata = dc_mem_wdata;
            e_wr = dc_mem_write; e_rd = dc_mem_read && !dc_mem_write;
         end
         cur = who;
      end else if (mem_ready) begin
         last = cur; cur = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      end
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("ic_ready", ic_mem_ready, cur == 1 && mem_ready);
      chk("dc_ready", dc_mem_ready, cur == 2 && mem_ready);
      chk("ic_rdata", ic_mem_rdata, cur == 1 ? mem_rdata : 128'd0);
      chk("dc_rdata", dc_mem_rdata, cur == 2 ? mem_rdata : 128'd0);
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // memory answers after lat cycles; the served client drops its request after seeing ready
   task automatic respond(input int lat, input logic [127:0] d, input logic is_i);
      repeat (lat) tick;
      mem_rdata = d;
      mem_ready = 1'b1;
      #1;
      chk("rsp_ready", is_i ? ic_mem_ready : dc_mem_ready, 1'b1);
      chk("rsp_rdata", is_i ? ic_mem_rdata : dc_mem_rdata, d);
      chk("rsp_other_ready", is_i ? dc_mem_ready : ic_mem_ready, 1'b0);
      chk("rsp_other_rdata", is_i ? dc_mem_rdata : ic_mem_rdata, 128'd0);
      tick;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (is_i) ic_mem_read = 1'b0;
      else begin
         dc_mem_read = 1'b0;
         dc_mem_write = 1'b0;
      end
      chk("done_read", mem_read, 1'b0);
      chk("done_write", mem_write, 1'b0);
      chk("done_addr", mem_addr, 28'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      ic_mem_read = 0; ic_mem_addr = '0;
      dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      #2;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_addr", mem_addr, 28'h0);
      chk("rst_ic_ready", ic_mem_ready, 1'b0);
      chk("rst_dc_rdata", dc_mem_rdata, 128'd0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      // tie right after reset: D first, then I after one idle cycle
      ic_mem_read = 1; ic_mem_addr = 28'h0000111;
      dc_mem_read = 1; dc_mem_addr = 28'h0000222;
      tick;
      chk("tie1_addr", mem_addr, 28'h0000222);
      chk("tie1_read", mem_read, 1'b1);
      respond(2, 128'h11112222333344445555666677778888, 1'b0);
      tick;
      chk("tie1_next_addr", mem_addr, 28'h0000111);
      chk("tie1_next_read", mem_read, 1'b1);
      respond(1, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1'b1);
      // I-only read
      ic_mem_read = 1; ic_mem_addr = 28'h0000123;
      tick;
      chk("iread_read", mem_read, 1'b1);
      chk("iread_write", mem_write, 1'b0);
      chk("iread_addr", mem_addr, 28'h0000123);
      respond(4, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 1'b1);
      // D write-back
      dc_mem_write = 1; dc_mem_addr = 28'h0ABCDEF;
      dc_mem_wdata = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
      tick;
      chk("wb_write", mem_write, 1'b1);
      chk("wb_read", mem_read, 1'b0);
      chk("wb_addr", mem_addr, 28'h0ABCDEF);
      chk("wb_wdata", mem_wdata, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);
      tick;
      chk("wb_wdata_hold", mem_wdata, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);
      respond(2, 128'h0, 1'b0);
      // tie with D served last: I wins
      ic_mem_read = 1; ic_mem_addr = 28'h0000333;
      dc_mem_read = 1; dc_mem_addr = 28'h0000444;
      tick;
      chk("tie2_addr", mem_addr, 28'h0000333);
      respond(2, 128'h33333333333333333333333333333333, 1'b1);
      tick;
      chk("tie2_next_addr", mem_addr, 28'h0000444);
      respond(1, 128'h44444444444444444444444444444444, 1'b0);
      // stray ready in IDLE
      tick;
      mem_ready = 1; mem_rdata = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
      #1;
      chk("stray_ic_ready", ic_mem_ready, 1'b0);
      chk("stray_dc_ready", dc_mem_ready, 1'b0);
      chk("stray_dc_rdata", dc_mem_rdata, 128'd0);
      tick;
      mem_ready = 0; mem_rdata = '0;
      chk("stray_read", mem_read, 1'b0);
      chk("stray_addr", mem_addr, 28'h0);
      // illegal D read+write: write wins
      dc_mem_read = 1; dc_mem_write = 1; dc_mem_addr = 28'h0000555;
      dc_mem_wdata = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
      tick;
      chk("rw_write", mem_write, 1'b1);
      chk("rw_read", mem_read, 1'b0);
      respond(1, 128'h0, 1'b0);
      // reset in the middle of a D write-back
      dc_mem_write = 1; dc_mem_addr = 28'h0FEDCBA;
      dc_mem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
      tick;
      chk("rmid_write", mem_write, 1'b1);
      tick;
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_write_clr", mem_write, 1'b0);
      chk("rmid_addr_clr", mem_addr, 28'h0);
      chk("rmid_wdata_clr", mem_wdata, 128'd0);
      dc_mem_write = 0;
      tick;
      rst_n = 1'b1;
      tick;
      mem_ready = 1; mem_rdata = 128'h77777777777777777777777777777777;
      #1;
      chk("late_dc_ready", dc_mem_ready, 1'b0);
      chk("late_ic_ready", ic_mem_ready, 1'b0);
      tick;
      mem_ready = 0; mem_rdata = '0;
      chk("late_write", mem_write, 1'b0);
      ic_mem_read = 1; ic_mem_addr = 28'h0000777;
      tick;
      chk("post_rst_read", mem_read, 1'b1);
      chk("post_rst_addr", mem_addr, 28'h0000777);
      respond(2, 128'h89898989898989898989898989898989, 1'b1);
      tick; tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
